dsp_mac_sequencer: RTL and testbench
====================================

// Module: dsp_mac_sequencer
// PURPOSE
//  Sequences one DSP48A1-style slice (A/B reg -> M reg -> P reg) through an N-term signed multiply-accumulate job.
//  Accepts operand pairs on a valid/ready stream and drives slice data, clock enables and accumulate select.
//  Returns the final 48-bit P value on a valid/ready result port.
//  Sits between a job source (filter/dot-product engine) and the slice wrapper.
// PARAMETERS
//  WA     18  width of operand A (signed)
//  WB     18  width of operand B (signed)
//  PW     48  width of slice P / result
//  LEN_W  8   width of cfg_len (max job length 2^LEN_W-1 terms)
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst        in   1      asynchronous, active-high reset
//  start      in   1      begin job; sampled only in IDLE
//  cfg_len    in   LEN_W  number of operand pairs in job; sampled with start
//  busy       out  1      high in every state except IDLE
//  done       out  1      one-cycle pulse on the result handshake cycle
//  op_valid   in   1      operand pair valid
//  op_ready   out  1      high only in ISSUE while issued count < len
//  op_a       in   WA     operand A
//  op_b       in   WB     operand B
//  dsp_a      out  WA     to slice A input; equals op_a (combinational)
//  dsp_b      out  WB     to slice B input; equals op_b (combinational)
//  dsp_ce_ab  out  1      slice A/B register enable
//  dsp_ce_m   out  1      slice M register enable
//  dsp_ce_p   out  1      slice P register enable
//  dsp_acc    out  1      P-stage select: 0 P<=M, 1 P<=P+M
//  dsp_p      in   PW     slice P output
//  res_valid  out  1      result valid; held until res_ready
//  res_ready  in   1      result consumer ready
//  res_data   out  PW     captured P of completed job
// BEHAVIOUR
//  Reset: state IDLE; counters, token pipe, res_data = 0; all outputs 0.
//  FSM IDLE -> ISSUE on start && cfg_len!=0 (len latched); start with cfg_len==0 ignored.
//  ISSUE: op_ready=1 while issued<len; accept = op_valid&&op_ready; dsp_ce_ab=accept (same cycle).
//  Token pipe, 2 stages, carries {valid,first}: first=1 for the job's first accepted pair.
//  dsp_ce_m = stage1 valid (cycle after accept); dsp_ce_p = stage2 valid; dsp_acc = stage2 valid && !stage2 first.
//  Bubbles (op_valid low) freeze nothing else; enables only pulse for real tokens, so P never absorbs stale M.
//  ISSUE -> DRAIN when issued==len (after last accept); DRAIN waits until token pipe empty, plus one cycle.
//  DRAIN capture: res_data<=dsp_p in the cycle after the last dsp_ce_p; state -> HOLD, res_valid=1.
//  Latency: res_valid rises exactly 4 cycles after the cycle the last pair is accepted.
//  HOLD: res_valid and res_data stable until res_valid&&res_ready; that cycle done=1, -> IDLE.
//  Back-to-back: start in the IDLE cycle after done accepted; start while busy ignored, cfg_len changes ignored.
//  Arithmetic: signed WAxWB product sign-extended in slice; accumulation wraps modulo 2^PW, no saturation/flag.
//  Reset mid-job: immediate return to IDLE, outputs 0, partial result discarded; slice P contents irrelevant
//   because the next job's first token loads P with dsp_acc=0.
//  dsp_ce_* never asserted in IDLE or HOLD.
// TESTING
//  len=4, a=1,2,3,4, b=2 back-to-back -> res_data=20, res_valid 4 cycles after 4th accept, done on handshake.
//  len=3, a=-3,7,100 b=5,-2,1, op_valid bubbles between pairs -> res_data=sext(71); ce_m/ce_p pulse once per pair.
//  len=1, a=-131072,b=-131072 -> res_data=48'h0004_0000_0000; dsp_acc never 1.
//  res_ready low 5 cycles -> res_valid/res_data stable, done only on ready cycle; start in HOLD ignored.
//  rst asserted mid-ISSUE after 2 of 4 pairs -> all outputs 0 async; next job len=2 a=1,1 b=1,1 -> 2.
//  start with cfg_len=0 -> stays IDLE, busy=0, op_ready=0, no done.

Source files
------------

// File: rtl/dsp_mac_sequencer_if.sv
// Job-control, operand-stream and result-stream bundle between a job source
// (master) and the MAC sequencer (slave).
interface dsp_mac_sequencer_if #(
  parameter int unsigned WA    = 18,
  parameter int unsigned WB    = 18,
  parameter int unsigned PW    = 48,
  parameter int unsigned LEN_W = 8
);
  logic                    start;
  logic [LEN_W-1:0]        cfg_len;
  logic                    busy;
  logic                    done;
  logic                    op_valid;
  logic                    op_ready;
  logic signed [WA-1:0]    op_a;
  logic signed [WB-1:0]    op_b;
  logic                    res_valid;
  logic                    res_ready;
  logic [PW-1:0]           res_data;

  modport master (
    output start, cfg_len, op_valid, op_a, op_b, res_ready,
    input  busy, done, op_ready, res_valid, res_data
  );

  modport slave (
    input  start, cfg_len, op_valid, op_a, op_b, res_ready,
    output busy, done, op_ready, res_valid, res_data
  );
endinterface

// File: rtl/dsp_mac_sequencer.sv
// Drives one A/B-reg -> M-reg -> P-reg DSP slice through an N-term signed
// multiply-accumulate job and returns the final P value on a result stream.
module dsp_mac_sequencer #(
  parameter int unsigned WA    = 18,
  parameter int unsigned WB    = 18,
  parameter int unsigned PW    = 48,
  parameter int unsigned LEN_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  dsp_mac_sequencer_if.slave   job,
  output logic [WA-1:0]        dsp_a,
  output logic [WB-1:0]        dsp_b,
  output logic                 dsp_ce_ab,
  output logic                 dsp_ce_m,
  output logic                 dsp_ce_p,
  output logic                 dsp_acc,
  input  logic [PW-1:0]        dsp_p
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_HOLD  = 2'd3
  } state_e;

  state_e           state_q,      state_d;
  logic [LEN_W-1:0] len_q,        len_d;
  logic [LEN_W-1:0] issued_q,     issued_d;
  logic             s1_valid_q,   s1_valid_d;
  logic             s1_first_q,   s1_first_d;
  logic             s2_valid_q,   s2_valid_d;
  logic             s2_first_q,   s2_first_d;
  logic             res_valid_q,  res_valid_d;
  logic [PW-1:0]    res_data_q,   res_data_d;

  logic             op_ready_c;
  logic             accept_c;
  logic             done_c;
  logic [LEN_W-1:0] issued_inc_c;

  // Next-state, token pipe and result capture.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    issued_d    = issued_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    done_c      = 1'b0;

    op_ready_c   = (state_q == S_ISSUE) && (issued_q < len_q);
    accept_c     = job.op_valid && op_ready_c;
    issued_inc_c = LEN_W'(issued_q + LEN_W'(1));

    // Tokens advance every cycle; bubbles simply leave an invalid slot.
    s1_valid_d = accept_c;
    s1_first_d = accept_c && (issued_q == '0);
    s2_valid_d = s1_valid_q;
    s2_first_d = s1_first_q;

    unique case (state_q)
      S_IDLE: begin
        if (job.start && (job.cfg_len != '0)) begin
          len_d    = job.cfg_len;
          issued_d = '0;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (accept_c) begin
          issued_d = issued_inc_c;
          if (issued_inc_c == len_q) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // Pipe empty means the last P load happened on the previous edge.
        if (!s1_valid_q && !s2_valid_q) begin
          res_data_d  = dsp_p;
          res_valid_d = 1'b1;
          state_d     = S_HOLD;
        end
      end
      S_HOLD: begin
        if (job.res_ready) begin
          done_c      = 1'b1;
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      issued_q    <= '0;
      s1_valid_q  <= 1'b0;
      s1_first_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_first_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      s1_valid_q  <= s1_valid_d;
      s1_first_q  <= s1_first_d;
      s2_valid_q  <= s2_valid_d;
      s2_first_q  <= s2_first_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  // Slice controls: the first token of a job loads P from M, the rest accumulate.
  assign dsp_a     = job.op_a;
  assign dsp_b     = job.op_b;
  assign dsp_ce_ab = accept_c;
  assign dsp_ce_m  = s1_valid_q;
  assign dsp_ce_p  = s2_valid_q;
  assign dsp_acc   = s2_valid_q && !s2_first_q;

  assign job.busy      = (state_q != S_IDLE);
  assign job.done      = done_c;
  assign job.op_ready  = op_ready_c;
  assign job.res_valid = res_valid_q;
  assign job.res_data  = res_data_q;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Directed bench for dsp_mac_sequencer with a behavioural A/B->M->P slice model.
module tb_dsp_mac_sequencer;
  localparam int unsigned WA    = 18;
  localparam int unsigned WB    = 18;
  localparam int unsigned PW    = 48;
  localparam int unsigned LEN_W = 8;

  logic clk;
  logic rst;
  logic [WA-1:0] dsp_a;
  logic [WB-1:0] dsp_b;
  logic dsp_ce_ab, dsp_ce_m, dsp_ce_p, dsp_acc;
  logic [PW-1:0] dsp_p;

  int errors = 0;
  int checks = 0;

  dsp_mac_sequencer_if #(.WA(WA), .WB(WB), .PW(PW), .LEN_W(LEN_W)) bus ();

  dsp_mac_sequencer #(.WA(WA), .WB(WB), .PW(PW), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .job       (bus),
    .dsp_a     (dsp_a),
    .dsp_b     (dsp_b),
    .dsp_ce_ab (dsp_ce_ab),
    .dsp_ce_m  (dsp_ce_m),
    .dsp_ce_p  (dsp_ce_p),
    .dsp_acc   (dsp_acc),
    .dsp_p     (dsp_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slice model; deliberately never reset so stale P survives a sequencer reset.
  logic signed [WA-1:0] sa_q;
  logic signed [WB-1:0] sb_q;
  logic signed [35:0]   prod;
  logic signed [PW-1:0] sm_q;
  logic signed [PW-1:0] sp_q;
  assign prod  = sa_q * sb_q;
  assign dsp_p = sp_q;
  always @(posedge clk) begin
    if (dsp_ce_ab) begin
      sa_q <= dsp_a;
      sb_q <= dsp_b;
    end
    if (dsp_ce_m) sm_q <= {{12{prod[35]}}, prod};
    if (dsp_ce_p) sp_q <= dsp_acc ? sp_q + sm_q : sm_q;
  end

  // Event monitors sampled mid-cycle.
  int cyc = 0;
  int cnt_m = 0, cnt_p = 0, cnt_acc = 0, cnt_done = 0;
  int last_acc_cyc = 0, rise_cyc = 0;
  logic prev_rv = 1'b0;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (dsp_ce_m) cnt_m++;
    if (dsp_ce_p) cnt_p++;
    if (dsp_acc) cnt_acc++;
    if (bus.done) cnt_done++;
    if (dsp_ce_ab) last_acc_cyc = cyc;
    if (bus.res_valid && !prev_rv) rise_cyc = cyc;
    prev_rv = bus.res_valid;
  end

  task automatic start_job(input int len);
    bus.start   = 1'b1;
    bus.cfg_len = LEN_W'(len);
    @(posedge clk); #1;
    bus.start   = 1'b0;
    bus.cfg_len = '0;
  endtask

  task automatic send_pair(input logic signed [WA-1:0] a, input logic signed [WB-1:0] b);
    int t = 0;
    bus.op_valid = 1'b1;
    bus.op_a     = a;
    bus.op_b     = b;
    #1;
    while (!bus.op_ready && t < 20) begin
      @(posedge clk); #2;
      t++;
    end
    checks++;
    if (t >= 20) begin
      errors++;
      $display("FAIL op_accept_timeout: op_ready=%0b required 1", bus.op_ready);
    end
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    bus.op_a     = '0;
    bus.op_b     = '0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_res();
    int t = 0;
    #1;
    while (!bus.res_valid && t < 20) begin
      @(posedge clk); #2;
      t++;
    end
    checks++;
    if (t >= 20) begin
      errors++;
      $display("FAIL res_valid_timeout: res_valid=%0b required 1", bus.res_valid);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.busy, bus.done, bus.op_ready, bus.res_valid, dsp_ce_ab, dsp_ce_m, dsp_ce_p, dsp_acc} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl: busy/done/op_ready/res_valid/ce_ab/ce_m/ce_p/acc=%b required 00000000",
               {bus.busy, bus.done, bus.op_ready, bus.res_valid, dsp_ce_ab, dsp_ce_m, dsp_ce_p, dsp_acc});
    end
    checks++;
    if (bus.res_data !== 48'd0) begin
      errors++;
      $display("FAIL reset_res_data: got %h required 0", bus.res_data);
    end
  endtask

  task automatic test_back_to_back();
    int m0 = cnt_m, p0 = cnt_p, a0 = cnt_acc, d0 = cnt_done;
    bus.res_ready = 1'b1;
    start_job(4);
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b required 1", bus.busy); end
    for (int i = 1; i <= 4; i++) send_pair(WA'(i), WB'(2));
    wait_res();
    checks++;
    if (bus.res_data !== 48'd20) begin errors++; $display("FAIL b2b_data: got %0d required 20", bus.res_data); end
    checks++;
    if (bus.done !== 1'b1) begin errors++; $display("FAIL b2b_done: got %b required 1", bus.done); end
    @(posedge clk); #1;
    checks++;
    if (rise_cyc - last_acc_cyc !== 4) begin
      errors++; $display("FAIL b2b_latency: got %0d required 4", rise_cyc - last_acc_cyc);
    end
    checks++;
    if ({bus.busy, bus.res_valid} !== 2'b00) begin
      errors++; $display("FAIL b2b_idle: busy/res_valid=%b required 00", {bus.busy, bus.res_valid});
    end
    checks++;
    if ({cnt_m - m0, cnt_p - p0, cnt_acc - a0, cnt_done - d0} !== {32'd4, 32'd4, 32'd3, 32'd1}) begin
      errors++; $display("FAIL b2b_counts: ce_m=%0d ce_p=%0d acc=%0d done=%0d required 4 4 3 1",
                         cnt_m - m0, cnt_p - p0, cnt_acc - a0, cnt_done - d0);
    end
  endtask

  task automatic test_bubbles();
    int m0 = cnt_m, p0 = cnt_p, a0 = cnt_acc;
    bus.res_ready = 1'b1;
    start_job(3);
    send_pair(-18'sd3, 18'sd5);
    idle_cycles(2);
    send_pair(18'sd7, -18'sd2);
    idle_cycles(3);
    send_pair(18'sd100, 18'sd1);
    wait_res();
    checks++;
    if (bus.res_data !== 48'd71) begin errors++; $display("FAIL bubble_data: got %0d required 71", bus.res_data); end
    @(posedge clk); #1;
    checks++;
    if (rise_cyc - last_acc_cyc !== 4) begin
      errors++; $display("FAIL bubble_latency: got %0d required 4", rise_cyc - last_acc_cyc);
    end
    checks++;
    if ({cnt_m - m0, cnt_p - p0, cnt_acc - a0} !== {32'd3, 32'd3, 32'd2}) begin
      errors++; $display("FAIL bubble_counts: ce_m=%0d ce_p=%0d acc=%0d required 3 3 2",
                         cnt_m - m0, cnt_p - p0, cnt_acc - a0);
    end
  endtask

  task automatic test_single_min();
    int a0 = cnt_acc, p0 = cnt_p;
    bus.res_ready = 1'b1;
    start_job(1);
    send_pair(-18'sd131072, -18'sd131072);
    wait_res();
    checks++;
    if (bus.res_data !== 48'h0004_0000_0000) begin
      errors++; $display("FAIL single_data: got %h required 000400000000", bus.res_data);
    end
    @(posedge clk); #1;
    checks++;
    if ({cnt_acc - a0, cnt_p - p0} !== {32'd0, 32'd1}) begin
      errors++; $display("FAIL single_counts: acc=%0d ce_p=%0d required 0 1", cnt_acc - a0, cnt_p - p0);
    end
  endtask

  task automatic test_hold();
    int d0 = cnt_done;
    bus.res_ready = 1'b0;
    start_job(2);
    send_pair(18'sd5, 18'sd1);
    send_pair(18'sd6, 18'sd1);
    wait_res();
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      bus.start   = (i == 2);
      bus.cfg_len = (i == 2) ? LEN_W'(3) : '0;
      #1;
      checks++;
      if ({bus.res_valid, bus.done, bus.op_ready, dsp_ce_ab, dsp_ce_m, dsp_ce_p} !== 6'b100000
          || bus.res_data !== 48'd11) begin
        errors++;
        $display("FAIL hold_stable[%0d]: rv/done/op_ready/ce_ab/ce_m/ce_p=%b data=%0d required 100000 data=11",
                 i, {bus.res_valid, bus.done, bus.op_ready, dsp_ce_ab, dsp_ce_m, dsp_ce_p}, bus.res_data);
      end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    bus.cfg_len = '0;
    bus.res_ready = 1'b1;
    #1;
    checks++;
    if (bus.done !== 1'b1) begin errors++; $display("FAIL hold_done: got %b required 1", bus.done); end
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    idle_cycles(2);
    checks++;
    if ({bus.busy, bus.op_ready, bus.res_valid} !== 3'b000 || cnt_done - d0 !== 1) begin
      errors++; $display("FAIL hold_after: busy/op_ready/rv=%b dones=%0d required 000 dones=1",
                         {bus.busy, bus.op_ready, bus.res_valid}, cnt_done - d0);
    end
  endtask

  task automatic test_mid_reset();
    bus.res_ready = 1'b1;
    start_job(4);
    send_pair(18'sd9, 18'sd9);
    send_pair(18'sd9, 18'sd9);
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.op_ready, bus.res_valid, dsp_ce_ab, dsp_ce_m, dsp_ce_p, dsp_acc} !== 8'h00
        || bus.res_data !== 48'd0) begin
      errors++;
      $display("FAIL midrst_outputs: ctrl=%b data=%h required 00000000 data=0",
               {bus.busy, bus.done, bus.op_ready, bus.res_valid, dsp_ce_ab, dsp_ce_m, dsp_ce_p, dsp_acc}, bus.res_data);
    end
    @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;
    start_job(2);
    send_pair(18'sd1, 18'sd1);
    send_pair(18'sd1, 18'sd1);
    wait_res();
    checks++;
    if (bus.res_data !== 48'd2) begin errors++; $display("FAIL midrst_next_job: got %0d required 2", bus.res_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_zero_len();
    int d0 = cnt_done;
    start_job(0);
    #1;
    checks++;
    if ({bus.busy, bus.op_ready} !== 2'b00) begin
      errors++; $display("FAIL zero_len_idle: busy/op_ready=%b required 00", {bus.busy, bus.op_ready});
    end
    idle_cycles(3);
    checks++;
    if (bus.busy !== 1'b0 || cnt_done - d0 !== 0) begin
      errors++; $display("FAIL zero_len_after: busy=%b dones=%0d required 0 0", bus.busy, cnt_done - d0);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.cfg_len = '0;
    bus.op_valid = 1'b0;
    bus.op_a = '0;
    bus.op_b = '0;
    bus.res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    idle_cycles(1);
    test_back_to_back();
    test_bubbles();
    test_single_min();
    test_hold();
    test_mid_reset();
    test_zero_len();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
